router_fsm_nch: RTL and testbench

Parametrised packet-router controller that sequences header decode, payload load, parity load/check and FIFO back-pressure for `NUM_CH` output FIFOs. It sits between the input byte register (header/parity logic) and the output FIFO bank, replacing the fixed 3-channel controller. It adds the following over that controller:
- Per-channel vectors for FIFO status and soft reset.
- A latched one-hot channel select.
- Checking of the addressed FIFO only.
- Illegal-address packet dropping.
- An optional wait-for-empty timeout.

---
 rtl/router_fsm_nch_pkg.sv | 28 ++
 rtl/router_fsm_nch_if.sv | 55 +++++
 rtl/router_fsm_nch_wait_timer.sv | 35 +++
 rtl/router_fsm_nch.sv | 160 ++++++++++++++++
 tb/tb_router_fsm_nch.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/router_fsm_nch_pkg.sv
// router_pkg
//   Shared types and constants for the N-channel packet-router controller.
//   - state_t     : 4-bit controller state encoding (9 states)
//   - DEF_NUM_CH  : default number of output channels/FIFOs
//   - DEF_ADDR_W  : default header address field width
//   - addr_legal(): true when a header address selects an existing channel
package router_pkg;

   localparam int DEF_NUM_CH = 3;
   localparam int DEF_ADDR_W = 2;

   typedef enum logic [3:0] {
      S_DECODE          = 4'd0,
      S_LOAD_FIRST      = 4'd1,
      S_LOAD_DATA       = 4'd2,
      S_WAIT_EMPTY      = 4'd3,
      S_LOAD_PARITY     = 4'd4,
      S_CHECK_PARITY    = 4'd5,
      S_FIFO_FULL       = 4'd6,
      S_LOAD_AFTER_FULL = 4'd7,
      S_DROP            = 4'd8
   } state_t;

   function automatic logic addr_legal(input int unsigned addr, input int unsigned num_ch);
      return (addr < num_ch);
   endfunction

endpackage

// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if
//   Bundles the controller's status inputs and control/decode outputs.
//   Modports:
//     slave  : the controller (router_fsm_nch) - consumes status, drives controls
//     master : the surrounding datapath / source side
//   Signals:
//     pkt_vd, din                     : packet valid and header address field
//     fifo_full, fifo_empty, sft_rst  : per-channel FIFO status / soft reset
//     parity_done, low_pkt_vd         : register-block status
//     detect_add .. full_state        : one-hot state decodes
//     write_enb_reg, rst_in_reg       : register-block controls
//     busy, ch_sel, drop_pkt          : source stall, latched channel, drop flag
//     dbg_state                       : raw state register
//   Flow control: the source presents a byte with pkt_vd=1; the byte is
//   accepted on every rising edge where busy=0 was presented in that cycle.
//   busy=1 means the source must hold its current byte and pkt_vd.
interface router_fsm_nch_if #(
   parameter int NUM_CH = router_pkg::DEF_NUM_CH,
   parameter int ADDR_W = router_pkg::DEF_ADDR_W
) ();
   import router_pkg::*;

   logic              pkt_vd;
   logic [ADDR_W-1:0] din;
   logic [NUM_CH-1:0] fifo_full;
   logic [NUM_CH-1:0] fifo_empty;
   logic [NUM_CH-1:0] sft_rst;
   logic              parity_done;
   logic              low_pkt_vd;

   logic              detect_add;
   logic              lfd_state;
   logic              ld_state;
   logic              laf_state;
   logic              full_state;
   logic              write_enb_reg;
   logic              rst_in_reg;
   logic              busy;
   logic [NUM_CH-1:0] ch_sel;
   logic              drop_pkt;
   state_t            dbg_state;

   modport slave (
      input  pkt_vd, din, fifo_full, fifo_empty, sft_rst, parity_done, low_pkt_vd,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_in_reg, busy, ch_sel, drop_pkt, dbg_state
   );

   modport master (
      output pkt_vd, din, fifo_full, fifo_empty, sft_rst, parity_done, low_pkt_vd,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_in_reg, busy, ch_sel, drop_pkt, dbg_state
   );

endinterface

// File: rtl/router_fsm_nch_wait_timer.sv
// router_wait_timer
//   Cycle counter for the WAIT_EMPTY timeout (built only with
//   ROUTER_FSM_WAIT_TIMEOUT_EN).
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     i_en      : count this cycle (controller is in WAIT_EMPTY)
//     i_clr     : clear the count (controller will not be in WAIT_EMPTY next)
//     o_expire  : this is the CYCLES-th consecutive enabled cycle
module router_wait_timer #(
   parameter int CYCLES = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire
);
   localparam int CNT_W = $clog2(CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Count holds the number of completed WAIT_EMPTY cycles, so reaching
   // LAST means the current cycle is the final one allowed.
   assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/router_fsm_nch.sv
// router_fsm_nch
//   Packet-router controller for NUM_CH output FIFOs: header decode, payload
//   load, parity load/check, FIFO back-pressure and illegal-address drop.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset (beats soft reset)
//     bus  : router_fsm_nch_if.slave (status in, decodes/controls out)
//   Build option:
//     ROUTER_FSM_WAIT_TIMEOUT_EN - when defined, WAIT_EMPTY gives up after
//     WAIT_TO_CYCLES cycles and drops the packet; otherwise it waits forever.
//   All outputs are registered from the next-state value, so they are pure
//   functions of the state register with no input-to-output paths.
module router_fsm_nch #(
   parameter int NUM_CH         = router_pkg::DEF_NUM_CH,
   parameter int ADDR_W         = router_pkg::DEF_ADDR_W,
   parameter int WAIT_TO_CYCLES = 30
) (
   input  logic                clk,
   input  logic                rst,
   router_fsm_nch_if.slave     bus
);
   import router_pkg::*;

   state_t            r_state;
   state_t            w_next_state;
   logic [NUM_CH-1:0] r_ch_sel;
   logic [NUM_CH-1:0] w_next_ch_sel;
   logic [NUM_CH-1:0] w_addr_1h;
   logic              w_legal;
   logic              w_addr_empty;
   logic              w_sel_full;
   logic              w_sel_empty;
   logic              w_sft_hit;
   logic              w_expire;

   logic r_detect_add, r_lfd_state, r_ld_state, r_laf_state, r_full_state;
   logic r_write_enb_reg, r_rst_in_reg, r_busy, r_drop_pkt;

   // Shifting past the top channel yields zero, so an illegal address never
   // matches any FIFO status bit.
   assign w_addr_1h    = NUM_CH'(1) << bus.din;
   assign w_legal      = addr_legal(32'(bus.din), 32'(NUM_CH));
   assign w_addr_empty = |(bus.fifo_empty & w_addr_1h);

   // Only the latched destination's status and soft reset are observed.
   assign w_sel_full   = |(bus.fifo_full  & r_ch_sel);
   assign w_sel_empty  = |(bus.fifo_empty & r_ch_sel);
   assign w_sft_hit    = |(bus.sft_rst    & r_ch_sel);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
   router_wait_timer #(
      .CYCLES (WAIT_TO_CYCLES)
   ) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .i_en     (r_state == S_WAIT_EMPTY),
      .i_clr    (w_next_state != S_WAIT_EMPTY),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_comb begin
      w_next_state  = r_state;
      w_next_ch_sel = r_ch_sel;
      case (r_state)
         S_DECODE: begin
            if (bus.pkt_vd) begin
               if (w_legal) begin
                  w_next_ch_sel = w_addr_1h;
                  w_next_state  = w_addr_empty ? S_LOAD_FIRST : S_WAIT_EMPTY;
               end else begin
                  w_next_state  = S_DROP;
               end
            end
         end
         S_LOAD_FIRST: w_next_state = S_LOAD_DATA;
         S_LOAD_DATA: begin
            if (w_sel_full)       w_next_state = S_FIFO_FULL;
            else if (!bus.pkt_vd) w_next_state = S_LOAD_PARITY;
         end
         S_WAIT_EMPTY: begin
            // Emptiness in the final timeout cycle still wins.
            if (w_sel_empty) begin
               w_next_state = S_LOAD_FIRST;
            end else if (w_expire) begin
               w_next_state  = S_DROP;
               w_next_ch_sel = '0;
            end
         end
         S_LOAD_PARITY:  w_next_state = S_CHECK_PARITY;
         S_CHECK_PARITY: w_next_state = w_sel_full ? S_FIFO_FULL : S_DECODE;
         S_FIFO_FULL: begin
            if (!w_sel_full) w_next_state = S_LOAD_AFTER_FULL;
         end
         S_LOAD_AFTER_FULL: begin
            if (bus.parity_done)     w_next_state = S_DECODE;
            else if (bus.low_pkt_vd) w_next_state = S_LOAD_PARITY;
            else                     w_next_state = S_LOAD_DATA;
         end
         S_DROP: begin
            if (!bus.pkt_vd) w_next_state = S_DECODE;
         end
         default: w_next_state = S_DECODE;
      endcase

      // A soft reset of the active channel aborts whatever the state wanted.
      if (w_sft_hit) w_next_state = S_DECODE;

      // The channel select never survives a return to DECODE.
      if (w_next_state == S_DECODE) w_next_ch_sel = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_DECODE;
         r_ch_sel        <= '0;
         r_detect_add    <= 1'b1;
         r_lfd_state     <= 1'b0;
         r_ld_state      <= 1'b0;
         r_laf_state     <= 1'b0;
         r_full_state    <= 1'b0;
         r_write_enb_reg <= 1'b0;
         r_rst_in_reg    <= 1'b0;
         r_busy          <= 1'b0;
         r_drop_pkt      <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_ch_sel        <= w_next_ch_sel;
         r_detect_add    <= (w_next_state == S_DECODE);
         r_lfd_state     <= (w_next_state == S_LOAD_FIRST);
         r_ld_state      <= (w_next_state == S_LOAD_DATA);
         r_laf_state     <= (w_next_state == S_LOAD_AFTER_FULL);
         r_full_state    <= (w_next_state == S_FIFO_FULL);
         r_write_enb_reg <= (w_next_state == S_LOAD_DATA)   ||
                            (w_next_state == S_LOAD_PARITY) ||
                            (w_next_state == S_LOAD_AFTER_FULL);
         r_rst_in_reg    <= (w_next_state == S_CHECK_PARITY);
         // Source may keep streaming while decoding, loading payload or dropping.
         r_busy          <= !((w_next_state == S_DECODE)    ||
                              (w_next_state == S_LOAD_DATA) ||
                              (w_next_state == S_DROP));
         r_drop_pkt      <= (w_next_state == S_DROP);
      end
   end

   assign bus.detect_add    = r_detect_add;
   assign bus.lfd_state     = r_lfd_state;
   assign bus.ld_state      = r_ld_state;
   assign bus.laf_state     = r_laf_state;
   assign bus.full_state    = r_full_state;
   assign bus.write_enb_reg = r_write_enb_reg;
   assign bus.rst_in_reg    = r_rst_in_reg;
   assign bus.busy          = r_busy;
   assign bus.ch_sel        = r_ch_sel;
   assign bus.drop_pkt      = r_drop_pkt;
   assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch
//   Directed bench for router_fsm_nch with NUM_CH=3, ADDR_W=2,
//   WAIT_TO_CYCLES=4. Each driven cycle pushes the expected post-edge state,
//   channel select and decode flags; a monitor compares them after each edge.
module tb_router_fsm_nch;
   import router_pkg::*;

   localparam int NCH = 3;
   localparam int AW  = 2;
   localparam int W   = 4 + NCH + 9;
   localparam logic [NCH-1:0] E7 = 3'b111;
   localparam logic [NCH-1:0] Z  = 3'b000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_rst = 1'b1;
   always #5 clk = ~clk;

   router_fsm_nch_if #(.NUM_CH(NCH), .ADDR_W(AW)) bus ();

   router_fsm_nch #(
      .NUM_CH         (NCH),
      .ADDR_W         (AW),
      .WAIT_TO_CYCLES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] w_act;
   logic [W-1:0] m_exp;
   string        m_name;

   assign w_act = {bus.dbg_state, bus.ch_sel, bus.detect_add, bus.lfd_state,
                   bus.ld_state, bus.laf_state, bus.full_state, bus.write_enb_reg,
                   bus.rst_in_reg, bus.busy, bus.drop_pkt};

   // Expected outputs written out from the output table: decodes, write
   // enable, parity-flag clear, source stall and drop flag for a state.
   function automatic logic [W-1:0] exp_vec(input state_t s, input logic [NCH-1:0] ch);
      logic detect, lfd, ld, laf, full, web, rin, bsy, drp;
      detect = (s == S_DECODE);
      lfd    = (s == S_LOAD_FIRST);
      ld     = (s == S_LOAD_DATA);
      laf    = (s == S_LOAD_AFTER_FULL);
      full   = (s == S_FIFO_FULL);
      web    = (s == S_LOAD_DATA) || (s == S_LOAD_PARITY) || (s == S_LOAD_AFTER_FULL);
      rin    = (s == S_CHECK_PARITY);
      bsy    = !((s == S_DECODE) || (s == S_LOAD_DATA) || (s == S_DROP));
      drp    = (s == S_DROP);
      return {s, ch, detect, lfd, ld, laf, full, web, rin, bsy, drp};
   endfunction

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         m_exp  = exp_q.pop_front();
         m_name = name_q.pop_front();
         n_tests++;
         if (w_act !== m_exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ch_sel=%b flags=%b, want state=%0d ch_sel=%b flags=%b",
                     m_name, w_act[W-1 -: 4], w_act[W-5 -: NCH], w_act[8:0],
                     m_exp[W-1 -: 4], m_exp[W-5 -: NCH], m_exp[8:0]);
         end
      end
   end

   // ---------------- driver ----------------
   // Drives one cycle of inputs at the falling edge and records what the
   // outputs must show after the following rising edge.
   task automatic cyc(input string nm, input logic pv, input logic [AW-1:0] d,
                      input logic [NCH-1:0] ff, input logic [NCH-1:0] fe,
                      input logic [NCH-1:0] sr, input logic pd, input logic lp,
                      input state_t es, input logic [NCH-1:0] ec);
      @(negedge clk);
      rst             = tb_rst;
      bus.pkt_vd      = pv;
      bus.din         = d;
      bus.fifo_full   = ff;
      bus.fifo_empty  = fe;
      bus.sft_rst     = sr;
      bus.parity_done = pd;
      bus.low_pkt_vd  = lp;
      exp_q.push_back(exp_vec(es, ec));
      name_q.push_back(nm);
   endtask

   initial begin
      int n_pay;
      bus.pkt_vd      = 1'b0;
      bus.din         = '0;
      bus.fifo_full   = Z;
      bus.fifo_empty  = E7;
      bus.sft_rst     = Z;
      bus.parity_done = 1'b0;
      bus.low_pkt_vd  = 1'b0;

      // reset
      cyc("reset_0", 0, 0, Z, E7, Z, 0, 0, S_DECODE, Z);
      cyc("reset_1", 0, 0, Z, E7, Z, 0, 0, S_DECODE, Z);
      tb_rst = 1'b0;
      cyc("idle", 0, 0, Z, E7, Z, 0, 0, S_DECODE, Z);

      // normal packet to channel 2
      cyc("hdr_ch2",   1, 2, Z, E7, Z, 0, 0, S_LOAD_FIRST, 3'b100);
      cyc("first_ch2", 1, 2, Z, E7, Z, 0, 0, S_LOAD_DATA,  3'b100);
      n_pay = $urandom_range(1, 4);
      for (int i = 0; i < n_pay; i++)
         cyc("payload_ch2", 1, 2, Z, E7, Z, 0, 0, S_LOAD_DATA, 3'b100);
      cyc("parity_ch2", 0, 2, Z, E7, Z, 0, 0, S_LOAD_PARITY,  3'b100);
      cyc("check_ch2",  0, 2, Z, E7, Z, 0, 0, S_CHECK_PARITY, 3'b100);
      cyc("done_ch2",   0, 2, Z, E7, Z, 0, 0, S_DECODE,       Z);

      // back-pressure on channel 1
      cyc("hdr_ch1",        1, 1, Z,      E7, Z, 0, 0, S_LOAD_FIRST,      3'b010);
      cyc("first_ch1",      1, 1, Z,      E7, Z, 0, 0, S_LOAD_DATA,       3'b010);
      cyc("other_full_ign", 1, 1, 3'b101, E7, Z, 0, 0, S_LOAD_DATA,       3'b010);
      cyc("full_ch1",       1, 1, 3'b010, E7, Z, 0, 0, S_FIFO_FULL,       3'b010);
      cyc("full_hold",      1, 1, 3'b010, E7, Z, 0, 0, S_FIFO_FULL,       3'b010);
      cyc("full_clear",     1, 1, Z,      E7, Z, 0, 0, S_LOAD_AFTER_FULL, 3'b010);
      cyc("laf_to_data",    1, 1, Z,      E7, Z, 0, 0, S_LOAD_DATA,       3'b010);
      cyc("full_again",     1, 1, 3'b010, E7, Z, 0, 0, S_FIFO_FULL,       3'b010);
      cyc("full_clear2",    0, 1, Z,      E7, Z, 0, 0, S_LOAD_AFTER_FULL, 3'b010);
      cyc("laf_low_pkt",    0, 1, Z,      E7, Z, 0, 1, S_LOAD_PARITY,     3'b010);
      cyc("check_ch1",      0, 1, Z,      E7, Z, 0, 0, S_CHECK_PARITY,    3'b010);
      cyc("done_ch1",       0, 1, Z,      E7, Z, 0, 0, S_DECODE,          Z);

      // FIFO fills during parity check, then parity_done ends the packet
      cyc("hdr_ch0",       1, 0, Z,      E7, Z, 0, 0, S_LOAD_FIRST,      3'b001);
      cyc("first_ch0",     0, 0, Z,      E7, Z, 0, 0, S_LOAD_DATA,       3'b001);
      cyc("parity_ch0",    0, 0, Z,      E7, Z, 0, 0, S_LOAD_PARITY,     3'b001);
      cyc("check_ch0",     0, 0, Z,      E7, Z, 0, 0, S_CHECK_PARITY,    3'b001);
      cyc("check_full",    0, 0, 3'b001, E7, Z, 0, 0, S_FIFO_FULL,       3'b001);
      cyc("check_unfull",  0, 0, Z,      E7, Z, 0, 0, S_LOAD_AFTER_FULL, 3'b001);
      cyc("laf_parity_dn", 0, 0, Z,      E7, Z, 1, 0, S_DECODE,          Z);

      // illegal address drop
      cyc("hdr_illegal", 1, 3, Z, E7, Z, 0, 0, S_DROP,   Z);
      cyc("drop_hold",   1, 3, Z, E7, Z, 0, 0, S_DROP,   Z);
      cyc("drop_end",    0, 3, Z, E7, Z, 0, 0, S_DECODE, Z);

      // hard reset while dropping
      cyc("hdr_illegal2", 1, 3, Z, E7, Z, 0, 0, S_DROP, Z);
      tb_rst = 1'b1;
      cyc("rst_in_drop",  1, 3, Z, E7, Z, 0, 0, S_DECODE, Z);
      tb_rst = 1'b0;

      // wait for empty, soft resets
      cyc("hdr_wait",      1, 0, Z, 3'b110, Z,      0, 0, S_WAIT_EMPTY, 3'b001);
      cyc("wait_hold",     1, 0, Z, 3'b110, Z,      0, 0, S_WAIT_EMPTY, 3'b001);
      cyc("sft_other_ign", 1, 0, Z, 3'b110, 3'b010, 0, 0, S_WAIT_EMPTY, 3'b001);
      cyc("sft_selected",  1, 0, Z, 3'b110, 3'b001, 0, 0, S_DECODE,     Z);

      // wait exits on empty, then soft reset beats LOAD_DATA->LOAD_PARITY
      cyc("hdr_wait2",   1, 0, Z, 3'b110, Z,      0, 0, S_WAIT_EMPTY, 3'b001);
      cyc("wait2_hold",  1, 0, Z, 3'b110, Z,      0, 0, S_WAIT_EMPTY, 3'b001);
      cyc("wait2_empty", 1, 0, Z, E7,     Z,      0, 0, S_LOAD_FIRST, 3'b001);
      cyc("first_wait2", 1, 0, Z, E7,     Z,      0, 0, S_LOAD_DATA,  3'b001);
      cyc("sft_wins",    0, 0, Z, E7,     3'b001, 0, 0, S_DECODE,     Z);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
      // timeout: 4 cycles in WAIT_EMPTY then DROP
      cyc("hdr_to", 1, 0, Z, 3'b110, Z, 0, 0, S_WAIT_EMPTY, 3'b001);
      for (int i = 0; i < 3; i++)
         cyc("to_wait", 1, 0, Z, 3'b110, Z, 0, 0, S_WAIT_EMPTY, 3'b001);
      cyc("to_expire",   1, 0, Z, 3'b110, Z, 0, 0, S_DROP,   Z);
      cyc("to_drop_end", 0, 0, Z, 3'b110, Z, 0, 0, S_DECODE, Z);
      // empty in the final cycle wins over the timeout
      cyc("hdr_to2", 1, 0, Z, 3'b110, Z, 0, 0, S_WAIT_EMPTY, 3'b001);
      for (int i = 0; i < 3; i++)
         cyc("to2_wait", 1, 0, Z, 3'b110, Z, 0, 0, S_WAIT_EMPTY, 3'b001);
      cyc("to2_empty_wins", 1, 0, Z, E7, Z, 0, 0, S_LOAD_FIRST, 3'b001);
      cyc("to2_first",      0, 0, Z, E7, Z, 0, 0, S_LOAD_DATA,  3'b001);
      cyc("to2_parity",     0, 0, Z, E7, Z, 0, 0, S_LOAD_PARITY, 3'b001);
      cyc("to2_check",      0, 0, Z, E7, Z, 0, 0, S_CHECK_PARITY, 3'b001);
      cyc("to2_done",       0, 0, Z, E7, Z, 0, 0, S_DECODE,     Z);
`else
      // without the timeout WAIT_EMPTY holds well past WAIT_TO_CYCLES
      cyc("hdr_nto", 1, 0, Z, 3'b110, Z, 0, 0, S_WAIT_EMPTY, 3'b001);
      for (int i = 0; i < 6; i++)
         cyc("nto_wait", 1, 0, Z, 3'b110, Z, 0, 0, S_WAIT_EMPTY, 3'b001);
      cyc("nto_sft", 0, 0, Z, 3'b110, 3'b001, 0, 0, S_DECODE, Z);
`endif

      cyc("final_idle", 0, 0, Z, E7, Z, 0, 0, S_DECODE, Z);

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
